// File: rtl/ad1xx_trace_pkg.sv
// Shared types for the ad1xx retire trace checker: trace entry layout,
// checker FSM states and the "no failure recorded" index value.
package ad1xx_trace_pkg;

    // Field widths of a stored trace entry.
    localparam int TRACE_XLEN   = 32;
    localparam int TRACE_RIDX_W = 5;

    // Wide all-ones constant; the top slices it to its own index width so
    // first_fail reads as all-ones while no mismatch has been seen.
    localparam logic [31:0] NO_FAIL_IDX = '1;

    // One expected retirement. An rd of zero means only the pc is checked.
    typedef struct packed {
        logic [TRACE_XLEN-1:0]   pc;
        logic [TRACE_RIDX_W-1:0] rd;
        logic [TRACE_XLEN-1:0]   wdata;
    } trace_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_t;

endpackage

// File: rtl/trace_mem.sv
// Expected-trace storage: DEPTH entries, synchronous write, asynchronous read.
// Contents are deliberately not reset so a trace survives a checker reset.
module trace_mem
    import ad1xx_trace_pkg::*;
#(
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  trace_entry_t  wentry,
    input  logic [AW-1:0] raddr,
    output trace_entry_t  rentry
);

    trace_entry_t mem [DEPTH];

    // Write one entry per cycle when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wentry;
        end
    end

    // Read is combinational so a retirement is checked in the cycle it arrives.
    assign rentry = mem[raddr];

endmodule

// File: rtl/retire_trace_checker.sv
// Retire trace checker: compares each CPU retirement against a preloaded
// expected trace and reports pass/fail, a saturating mismatch count, the
// first failing index and a no-retire timeout.
//
// Handshake: retire_valid is a one-cycle strobe with no back-pressure; every
// cycle it is high during RUN consumes exactly one trace entry. load_we and
// start are likewise single-cycle strobes, honoured only outside RUN.
//
// Optional: define RETIRE_TRACE_DISPLAY_EN to print every checked retirement
// and a summary line at completion (simulation only; ports are unaffected).
module retire_trace_checker
    import ad1xx_trace_pkg::*;
#(
    parameter int XLEN    = TRACE_XLEN,
    parameter int RIDX_W  = TRACE_RIDX_W,
    parameter int DEPTH   = 64,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 8,
    localparam int IDX_W  = $clog2(DEPTH),
    localparam int LEN_W  = IDX_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_we,
    input  logic [IDX_W-1:0]  load_addr,
    input  logic [XLEN-1:0]   load_pc,
    input  logic [RIDX_W-1:0] load_rd,
    input  logic [XLEN-1:0]   load_wdata,
    input  logic [LEN_W-1:0]  num_entries,
    input  logic              start,
    input  logic              retire_valid,
    input  logic [XLEN-1:0]   retire_pc,
    input  logic [RIDX_W-1:0] retire_rd,
    input  logic [XLEN-1:0]   retire_wdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timed_out,
    output logic [CNT_W-1:0]  fail_count,
    output logic [LEN_W-1:0]  first_fail
);

    localparam int TMR_W = $clog2(TIMEOUT) + 1;
    localparam logic [LEN_W-1:0] NO_FAIL = NO_FAIL_IDX[LEN_W-1:0];
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DEPTH);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    chk_state_t        state, state_nx;
    logic [LEN_W-1:0]  len_q;
    logic [IDX_W-1:0]  idx_q;
    logic [TMR_W-1:0]  timer_q;
    logic [CNT_W-1:0]  fail_count_q;
    logic [LEN_W-1:0]  first_fail_q;
    logic              timed_out_q;

    trace_entry_t      wr_entry;
    trace_entry_t      exp_entry;
    logic              mem_we;
    logic [LEN_W-1:0]  start_len;
    logic              begin_run;
    logic              last_entry;
    logic              timeout_hit;
    logic              mismatch;

    // ------------------------------------------------------------------
    // Trace storage; writes are locked out while a run is in progress.
    // ------------------------------------------------------------------
    assign mem_we   = load_we && (state != RUN);
    assign wr_entry = '{pc: load_pc, rd: load_rd, wdata: load_wdata};

    trace_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk    (clk),
        .we     (mem_we),
        .waddr  (load_addr),
        .wentry (wr_entry),
        .raddr  (idx_q),
        .rentry (exp_entry)
    );

    // ------------------------------------------------------------------
    // Decode helpers
    // ------------------------------------------------------------------
    // Trace lengths above DEPTH are clamped so idx can never run past memory.
    assign start_len   = (num_entries > MAX_LEN) ? MAX_LEN : num_entries;
    assign begin_run   = start && (state != RUN);
    assign last_entry  = ({1'b0, idx_q} == (len_q - LEN_W'(1)));
    assign timeout_hit = (timer_q == TMR_LAST);

    // pc is always checked; rd and wdata only when a destination is expected.
    assign mismatch = (retire_pc != exp_entry.pc) ||
                      ((exp_entry.rd != '0) &&
                       ((retire_rd != exp_entry.rd) || (retire_wdata != exp_entry.wdata)));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: start leaves IDLE/DONE, last retirement or timeout ends RUN.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx = (start_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (retire_valid) begin
                    if (last_entry) begin
                        state_nx = DONE;
                    end
                end else if (timeout_hit) begin
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Run bookkeeping: length latch, entry index, idle timer and results.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q        <= '0;
            idx_q        <= '0;
            timer_q      <= '0;
            fail_count_q <= '0;
            first_fail_q <= NO_FAIL;
            timed_out_q  <= 1'b0;
        end else if (begin_run) begin
            len_q        <= start_len;
            idx_q        <= '0;
            timer_q      <= '0;
            fail_count_q <= '0;
            first_fail_q <= NO_FAIL;
            timed_out_q  <= 1'b0;
        end else if (state == RUN) begin
            if (retire_valid) begin
                timer_q <= '0;
                idx_q   <= idx_q + 1'b1;
                if (mismatch) begin
                    if (fail_count_q != '1) begin
                        fail_count_q <= fail_count_q + 1'b1;
                    end
                    if (first_fail_q == NO_FAIL) begin
                        first_fail_q <= {1'b0, idx_q};
                    end
                end
            end else begin
                timer_q <= timer_q + 1'b1;
                if (timeout_hit) begin
                    timed_out_q <= 1'b1;
                end
            end
        end
    end

    assign busy       = (state == RUN);
    assign done       = (state == DONE);
    assign pass       = done && (fail_count_q == '0) && !timed_out_q;
    assign timed_out  = timed_out_q;
    assign fail_count = fail_count_q;
    assign first_fail = first_fail_q;

`ifdef RETIRE_TRACE_DISPLAY_EN
    logic disp_done_q;

    // Remember the previous done level so the summary prints once per run.
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_done_q <= 1'b0;
        end else begin
            disp_done_q <= done;
        end
    end

    // Log each checked retirement and the end-of-run verdict.
    always @(posedge clk) begin
        if (!reset && (state == RUN) && retire_valid) begin
            if (mismatch) begin
                $display("[retire_trace] idx %0d pc %h rd x%0d wdata %h MISMATCH (exp pc %h rd x%0d wdata %h)",
                         idx_q, retire_pc, retire_rd, retire_wdata,
                         exp_entry.pc, exp_entry.rd, exp_entry.wdata);
            end else begin
                $display("[retire_trace] idx %0d pc %h rd x%0d wdata %h OK",
                         idx_q, retire_pc, retire_rd, retire_wdata);
            end
        end
        if (!reset && done && !disp_done_q) begin
            if (timed_out_q) begin
                $display("[retire_trace] TIMEOUT after %0d entries, %0d mismatches", idx_q, fail_count_q);
            end else if (fail_count_q != '0) begin
                $display("[retire_trace] FAIL: %0d mismatches, first at idx %0d", fail_count_q, first_fail_q);
            end else begin
                $display("[retire_trace] PASS: %0d entries", len_q);
            end
        end
    end
`endif

endmodule

// File: tb/tb_retire_trace_checker.sv
// Bench for retire_trace_checker: directed table, directed multi-cycle
// sequences and randomized runs checked against a trace-level model.
module tb_retire_trace_checker;

    localparam int XLEN    = 32;
    localparam int RIDX_W  = 5;
    localparam int DEPTH   = 512;
    localparam int TIMEOUT = 100;
    localparam int CNT_W   = 8;
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int LEN_W   = IDX_W + 1;
    localparam logic [LEN_W-1:0] NONE = '1;

    logic              clk;
    logic              reset;
    logic              load_we;
    logic [IDX_W-1:0]  load_addr;
    logic [XLEN-1:0]   load_pc;
    logic [RIDX_W-1:0] load_rd;
    logic [XLEN-1:0]   load_wdata;
    logic [LEN_W-1:0]  num_entries;
    logic              start;
    logic              retire_valid;
    logic [XLEN-1:0]   retire_pc;
    logic [RIDX_W-1:0] retire_rd;
    logic [XLEN-1:0]   retire_wdata;
    logic              busy;
    logic              done;
    logic              pass;
    logic              timed_out;
    logic [CNT_W-1:0]  fail_count;
    logic [LEN_W-1:0]  first_fail;

    retire_trace_checker #(
        .XLEN(XLEN), .RIDX_W(RIDX_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .load_we(load_we), .load_addr(load_addr), .load_pc(load_pc),
        .load_rd(load_rd), .load_wdata(load_wdata),
        .num_entries(num_entries), .start(start),
        .retire_valid(retire_valid), .retire_pc(retire_pc),
        .retire_rd(retire_rd), .retire_wdata(retire_wdata),
        .busy(busy), .done(done), .pass(pass), .timed_out(timed_out),
        .fail_count(fail_count), .first_fail(first_fail)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    // Model of the expected trace as the bench loaded it.
    logic [XLEN-1:0]   m_pc [DEPTH];
    logic [RIDX_W-1:0] m_rd [DEPTH];
    logic [XLEN-1:0]   m_wd [DEPTH];

    // Scoreboard: expected fail_count after each retirement in a random run.
    logic [CNT_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_entry(input int addr, input logic [XLEN-1:0] pc,
                              input logic [RIDX_W-1:0] rd, input logic [XLEN-1:0] wd);
        load_we = 1'b1; load_addr = IDX_W'(addr);
        load_pc = pc; load_rd = rd; load_wdata = wd;
        tick();
        load_we = 1'b0;
        m_pc[addr] = pc; m_rd[addr] = rd; m_wd[addr] = wd;
    endtask

    task automatic start_run(input int n);
        num_entries = LEN_W'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic retire(input logic [XLEN-1:0] pc, input logic [RIDX_W-1:0] rd,
                          input logic [XLEN-1:0] wd);
        retire_valid = 1'b1;
        retire_pc = pc; retire_rd = rd; retire_wdata = wd;
        tick();
        retire_valid = 1'b0;
    endtask

    // Rule: wrong pc always fails; rd/wdata only matter when rd is expected.
    function automatic bit model_wrong(input int i, input logic [XLEN-1:0] pc,
                                       input logic [RIDX_W-1:0] rd, input logic [XLEN-1:0] wd);
        if (pc != m_pc[i]) return 1'b1;
        if (m_rd[i] == 0) return 1'b0;
        return (rd != m_rd[i]) || (wd != m_wd[i]);
    endfunction

    // ---------------- directed table ----------------
    typedef struct {
        logic [XLEN-1:0]   epc;
        logic [RIDX_W-1:0] erd;
        logic [XLEN-1:0]   ewd;
        logic [XLEN-1:0]   rpc;
        logic [RIDX_W-1:0] rrd;
        logic [XLEN-1:0]   rwd;
        bit                wrong;
    } vec_t;

    vec_t vt[8];

    initial begin
        int  k;
        int  exp_cnt;
        logic [LEN_W-1:0] exp_ff;
        int  len, wrong_n, first_w;
        logic [XLEN-1:0] pc, wd;
        logic [RIDX_W-1:0] rd;
        int  kind;

        vt[0] = '{32'h100,      5'd1,  32'hAAAA,     32'h100,      5'd1,  32'hAAAA,     1'b0};
        vt[1] = '{32'h104,      5'd2,  32'h1,        32'h108,      5'd2,  32'h1,        1'b1};
        vt[2] = '{32'h108,      5'd0,  32'h5,        32'h108,      5'd7,  32'h99,       1'b0};
        vt[3] = '{32'h10C,      5'd3,  32'hFFFFFFFF, 32'h10C,      5'd3,  32'h7FFFFFFF, 1'b1};
        vt[4] = '{32'h110,      5'd4,  32'h0,        32'h110,      5'd5,  32'h0,        1'b1};
        vt[5] = '{32'h114,      5'd0,  32'h0,        32'h914,      5'd0,  32'h0,        1'b1};
        vt[6] = '{32'h80000000, 5'd31, 32'h12345678, 32'h80000000, 5'd31, 32'h12345678, 1'b0};
        vt[7] = '{32'h11C,      5'd9,  32'hDEAD,     32'h11C,      5'd9,  32'hDEAD,     1'b0};

        reset = 1'b1; load_we = 0; load_addr = 0; load_pc = 0; load_rd = 0; load_wdata = 0;
        num_entries = 0; start = 0; retire_valid = 0; retire_pc = 0; retire_rd = 0; retire_wdata = 0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_timed_out", timed_out, 0);
        check("rst_fail_count", fail_count, 0);
        check("rst_first_fail", first_fail, NONE);

        // Table: load, run, compare running results per row
        for (int i = 0; i < 8; i++) load_entry(i, vt[i].epc, vt[i].erd, vt[i].ewd);
        start_run(8);
        check("tbl_busy", busy, 1);
        exp_cnt = 0; exp_ff = NONE;
        for (int i = 0; i < 8; i++) begin
            if (vt[i].wrong) begin
                exp_cnt++;
                if (exp_ff == NONE) exp_ff = LEN_W'(i);
            end
            retire(vt[i].rpc, vt[i].rrd, vt[i].rwd);
            check($sformatf("tbl_fail_count[%0d]", i), fail_count, exp_cnt);
            check($sformatf("tbl_first_fail[%0d]", i), first_fail, exp_ff);
            check($sformatf("tbl_done[%0d]", i), done, (i == 7));
        end
        check("tbl_pass", pass, 0);

        // 1. Matching three-entry trace
        load_entry(0, 32'h0, 5'd12, 32'h5);
        load_entry(1, 32'h4, 5'd13, 32'hA);
        load_entry(2, 32'h8, 5'd0,  32'h0);
        start_run(3);
        retire(32'h0, 5'd12, 32'h5);
        retire(32'h4, 5'd13, 32'hA);
        check("t1_not_done_early", done, 0);
        retire(32'h8, 5'd0, 32'h77);
        check("t1_done", done, 1);
        check("t1_pass", pass, 1);
        check("t1_fail_count", fail_count, 0);
        check("t1_first_fail", first_fail, NONE);

        // 2. Wrong wdata at idx 1, restarted from DONE
        start_run(3);
        retire(32'h0, 5'd12, 32'h5);
        retire(32'h4, 5'd13, 32'hB);
        retire(32'h8, 5'd0, 32'h0);
        check("t2_done", done, 1);
        check("t2_pass", pass, 0);
        check("t2_fail_count", fail_count, 1);
        check("t2_first_fail", first_fail, 1);

        // 3. Timeout measured from the last retirement
        load_entry(3, 32'hC, 5'd14, 32'hF);
        start_run(4);
        retire(32'h0, 5'd12, 32'h5);
        retire(32'h4, 5'd13, 32'hA);
        k = 0;
        while (!timed_out && k < 2 * TIMEOUT) begin
            tick();
            k++;
        end
        check("t3_timeout_cycles", k, TIMEOUT);
        check("t3_timed_out", timed_out, 1);
        check("t3_done", done, 1);
        check("t3_pass", pass, 0);
        check("t3_fail_count", fail_count, 0);

        // 4. Reset in RUN at idx 2, then re-run with memory intact
        start_run(4);
        retire(32'h0, 5'd12, 32'h5);
        retire(32'h4, 5'd13, 32'h0);
        check("t4_pre_fail_count", fail_count, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t4_busy", busy, 0);
        check("t4_done", done, 0);
        check("t4_fail_count", fail_count, 0);
        check("t4_first_fail", first_fail, NONE);
        start_run(4);
        for (int i = 0; i < 4; i++) retire(m_pc[i], m_rd[i], m_wd[i]);
        check("t4_rerun_pass", pass, 1);

        // Load and start in the same cycle: entry 0 visible to the first retirement
        load_we = 1'b1; load_addr = 0; load_pc = 32'h500; load_rd = 5'd3; load_wdata = 32'h33;
        num_entries = 2; start = 1'b1;
        tick();
        load_we = 1'b0; start = 1'b0;
        m_pc[0] = 32'h500; m_rd[0] = 5'd3; m_wd[0] = 32'h33;
        retire(32'h500, 5'd3, 32'h33);
        check("ls_fail_count", fail_count, 0);
        // load_we and start during RUN are ignored
        load_we = 1'b1; load_addr = 1; load_pc = 32'hBAD; load_rd = 5'd1; load_wdata = 32'h1;
        start = 1'b1; num_entries = 5;
        tick();
        load_we = 1'b0; start = 1'b0;
        check("ign_busy", busy, 1);
        retire(32'h4, 5'd13, 32'hA);
        check("ign_done", done, 1);
        check("ign_pass", pass, 1);

        // 5. Empty trace; retirements while DONE change nothing
        start_run(0);
        check("t5_done", done, 1);
        check("t5_pass", pass, 1);
        for (int i = 0; i < 3; i++) retire(32'hFFFF, 5'd1, 32'h1);
        check("t5_fail_count", fail_count, 0);
        check("t5_first_fail", first_fail, NONE);
        check("t5_still_pass", pass, 1);

        // Randomized runs against the trace model
        for (int r = 0; r < 25; r++) begin
            len = $urandom_range(1, 24);
            for (int i = 0; i < len; i++)
                load_entry(i, $urandom, ($urandom_range(0, 3) == 0) ? 5'd0 : RIDX_W'($urandom_range(1, 31)), $urandom);
            start_run(len);
            wrong_n = 0; first_w = -1;
            for (int i = 0; i < len; i++) begin
                pc = m_pc[i]; rd = m_rd[i]; wd = m_wd[i];
                kind = $urandom_range(0, 4);
                if (kind == 2) pc = pc ^ (32'h1 << $urandom_range(0, 31));
                if (kind == 3) rd = rd ^ RIDX_W'($urandom_range(1, 31));
                if (kind == 4) wd = wd ^ (32'h1 << $urandom_range(0, 31));
                if (model_wrong(i, pc, rd, wd)) begin
                    wrong_n++;
                    if (first_w < 0) first_w = i;
                end
                exp_q.push_back(CNT_W'((wrong_n > 255) ? 255 : wrong_n));
                retire(pc, rd, wd);
                check($sformatf("rnd%0d_fail_count[%0d]", r, i), fail_count, exp_q.pop_front());
                if (i != len - 1) begin
                    repeat ($urandom_range(0, 3)) tick();
                    if ((r % 5) == 0) begin
                        load_we = 1'b1; load_addr = IDX_W'(i + 1);
                        load_pc = $urandom; load_rd = 5'd7; load_wdata = $urandom;
                        start = 1'b1; num_entries = 1;
                        tick();
                        load_we = 1'b0; start = 1'b0;
                    end
                end
            end
            check($sformatf("rnd%0d_done", r), done, 1);
            check($sformatf("rnd%0d_pass", r), pass, (wrong_n == 0));
            check($sformatf("rnd%0d_first_fail", r), first_fail, (first_w < 0) ? NONE : LEN_W'(first_w));
        end

        // 6. 300 mismatches saturate the counter
        for (int i = 0; i < 300; i++) load_entry(i, 32'(i * 4), 5'd1, 32'(i));
        start_run(300);
        for (int i = 0; i < 300; i++) begin
            retire(32'(i * 4 + 2), 5'd1, 32'(i));
            if (i == 253) check("t6_fail_count_254", fail_count, 254);
            if (i == 254) check("t6_fail_count_255", fail_count, 255);
        end
        check("t6_fail_count_sat", fail_count, 8'hFF);
        check("t6_first_fail", first_fail, 0);
        check("t6_done", done, 1);
        check("t6_pass", pass, 0);

        // Oversized num_entries is clamped to DEPTH
        for (int i = 300; i < DEPTH; i++) load_entry(i, 32'(i * 4), 5'd2, 32'(i + 7));
        start_run(1023);
        for (int i = 0; i < DEPTH; i++) begin
            retire(m_pc[i], m_rd[i], m_wd[i]);
            if (i == DEPTH - 2) check("clamp_busy", busy, 1);
        end
        check("clamp_done", done, 1);
        check("clamp_pass", pass, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
